// File: rtl/lsu_mem_arbiter.sv
// Data-memory arbiter: routes the LSU lanes of both warps onto NUM_CHANNELS memory channels.
// A rotating pointer picks the next lane, and each channel runs a request/relay FSM.
//
// state          | meaning
// ---------------+-------------------------------------------------------------
// IDLE           | channel free, scanning lanes for a request
// READ_WAITING   | read issued on mem side, waiting for mem_read_ready
// WRITE_WAITING  | write issued on mem side, waiting for mem_write_ready
// READ_RELAYING  | read data/ready held to the lane until it drops read_valid
// WRITE_RELAYING | write ready held to the lane until it drops write_valid
module lsu_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

  localparam int LW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t                   state_q [NUM_CHANNELS];
  state_t                   state_d [NUM_CHANNELS];
  logic [LW-1:0]            lane_q  [NUM_CHANNELS];
  logic [LW-1:0]            lane_d  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  grant_vld;
  logic [NUM_CHANNELS-1:0]  grant_rd;
  logic [NUM_CONSUMERS-1:0] claimed_q;
  logic [NUM_CONSUMERS-1:0] claimed_d;
  logic [LW-1:0]            rr_ptr;
  logic [LW-1:0]            rr_ptr_d;

  logic [NUM_CONSUMERS-1:0] taken;
  logic                     found;
  logic [LW-1:0]            sel;

  logic [NUM_CHANNELS-1:0]                 mem_read_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address_d;
  logic [NUM_CHANNELS-1:0]                 mem_write_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_d;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        lane_q[c]  <= '0;
      end
      claimed_q            <= '0;
      rr_ptr               <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        lane_q[c]  <= lane_d[c];
      end
      claimed_q            <= claimed_d;
      rr_ptr               <= rr_ptr_d;
      mem_read_valid       <= mem_read_valid_d;
      mem_read_address     <= mem_read_address_d;
      mem_write_valid      <= mem_write_valid_d;
      mem_write_address    <= mem_write_address_d;
      mem_write_data       <= mem_write_data_d;
      consumer_read_ready  <= consumer_read_ready_d;
      consumer_read_data   <= consumer_read_data_d;
      consumer_write_ready <= consumer_write_ready_d;
    end
  end

  // Channels grant in ascending order; a lane picked here is masked for later channels.
  always_comb begin
    taken     = claimed_q;
    rr_ptr_d  = rr_ptr;
    grant_vld = '0;
    grant_rd  = '0;
    found     = 1'b0;
    sel       = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      lane_d[c]  = lane_q[c];
      found      = 1'b0;
      case (state_q[c])
        IDLE: begin
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            sel = LW'((int'(rr_ptr) + k) % NUM_CONSUMERS);
            if (!found && !taken[sel] &&
                (consumer_read_valid[sel] || consumer_write_valid[sel])) begin
              found        = 1'b1;
              taken[sel]   = 1'b1;
              lane_d[c]    = sel;
              grant_vld[c] = 1'b1;
              grant_rd[c]  = consumer_read_valid[sel];
              state_d[c]   = consumer_read_valid[sel] ? READ_WAITING : WRITE_WAITING;
              rr_ptr_d     = (sel == LW'(NUM_CONSUMERS - 1)) ? '0 : sel + 1'b1;
            end
          end
        end
        READ_WAITING:   if (mem_read_ready[c])                   state_d[c] = READ_RELAYING;
        WRITE_WAITING:  if (mem_write_ready[c])                  state_d[c] = WRITE_RELAYING;
        READ_RELAYING:  if (!consumer_read_valid[lane_q[c]])     state_d[c] = IDLE;
        WRITE_RELAYING: if (!consumer_write_valid[lane_q[c]])    state_d[c] = IDLE;
        default:        state_d[c] = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and the claim mask.
  always_comb begin
    claimed_d              = claimed_q;
    mem_read_valid_d       = mem_read_valid;
    mem_read_address_d     = mem_read_address;
    mem_write_valid_d      = mem_write_valid;
    mem_write_address_d    = mem_write_address;
    mem_write_data_d       = mem_write_data;
    consumer_read_ready_d  = consumer_read_ready;
    consumer_read_data_d   = consumer_read_data;
    consumer_write_ready_d = consumer_write_ready;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (state_q[c])
        IDLE: begin
          if (grant_vld[c]) begin
            claimed_d[lane_d[c]] = 1'b1;
            if (grant_rd[c]) begin
              mem_read_valid_d[c]   = 1'b1;
              mem_read_address_d[c] = consumer_read_address[lane_d[c]];
            end else begin
              mem_write_valid_d[c]   = 1'b1;
              mem_write_address_d[c] = consumer_write_address[lane_d[c]];
              mem_write_data_d[c]    = consumer_write_data[lane_d[c]];
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[c]) begin
            mem_read_valid_d[c]               = 1'b0;
            consumer_read_ready_d[lane_q[c]]  = 1'b1;
            consumer_read_data_d[lane_q[c]]   = mem_read_data[c];
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[c]) begin
            mem_write_valid_d[c]              = 1'b0;
            consumer_write_ready_d[lane_q[c]] = 1'b1;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[lane_q[c]]) begin
            consumer_read_ready_d[lane_q[c]] = 1'b0;
            claimed_d[lane_q[c]]             = 1'b0;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[lane_q[c]]) begin
            consumer_write_ready_d[lane_q[c]] = 1'b0;
            claimed_d[lane_q[c]]              = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_arbiter.md
# lsu_mem_arbiter

Arbitrates data-memory traffic from every LSU lane of a dual-warp core onto a smaller number of external memory channels. Its consumer side carries the flattened per-lane read/write channels of both warps: warp 1 lanes occupy indices 0..THREADS_PER_BLOCK-1, and warp 2 lanes follow. Its memory side drives the shared data-memory ports. Each channel runs a small request/relay state machine, and a rotating pointer selects among requesters, so no lane is starved.

## Interface
- ADDR_BITS, 8, data-memory address width
- DATA_BITS, 8, data-memory word width
- NUM_CONSUMERS, 8, LSU lanes served (2 x THREADS_PER_BLOCK)
- NUM_CHANNELS, 2, external memory channels (1..NUM_CONSUMERS)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- consumer_read_valid  in  [NUM_CONSUMERS]  lane read request
- consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  read address
- consumer_read_ready  out  [NUM_CONSUMERS]  read data valid / completion
- consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  returned word
- consumer_write_valid  in  [NUM_CONSUMERS]  lane write request
- consumer_write_address  in  [NUM_CONSUMERS][ADDR_BITS]  write address
- consumer_write_data  in  [NUM_CONSUMERS][DATA_BITS]  write word
- consumer_write_ready  out  [NUM_CONSUMERS]  write completion
- mem_read_valid  out  [NUM_CHANNELS]  channel read request
- mem_read_address  out  [NUM_CHANNELS][ADDR_BITS]  channel read address
- mem_read_ready  in  [NUM_CHANNELS]  memory read done, data valid
- mem_read_data  in  [NUM_CHANNELS][DATA_BITS]  memory read word
- mem_write_valid  out  [NUM_CHANNELS]  channel write request
- mem_write_address  out  [NUM_CHANNELS][ADDR_BITS]  channel write address
- mem_write_data  out  [NUM_CHANNELS][DATA_BITS]  channel write word
- mem_write_ready  in  [NUM_CHANNELS]  memory write done

## Operation
- Per-channel FSM states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- Per-consumer `claimed` bit. A lane that is claimed is invisible to all other channels.
- Round-robin pointer rr_ptr, range 0..NUM_CONSUMERS-1.
- Grant in IDLE: the channel scans lanes rr_ptr, rr_ptr+1, ... (wrapping modulo NUM_CONSUMERS) for the first unclaimed lane with read_valid or write_valid set.
  - If a lane asserts both, the read is granted first.
  - Grant latches address/data, sets claimed, and moves the FSM to *_WAITING.
- Simultaneous grants: channels evaluate in ascending index order within one cycle. A lane taken by channel c is excluded for channels > c, so two channels never grant the same lane.
- rr_ptr update: becomes (last lane granted this cycle + 1) mod NUM_CONSUMERS. Unchanged if there was no grant.
- READ_WAITING: mem_read_valid=1 with the latched address. On mem_read_ready: capture mem_read_data into consumer_read_data[lane], set consumer_read_ready[lane], drop mem_read_valid, go to READ_RELAYING.
- WRITE_WAITING: same pattern using the mem_write_* signals, then WRITE_RELAYING.
- *_RELAYING: hold consumer ready (and read data) until the lane deasserts its valid. Then clear ready and claimed, and return to IDLE.
- Consumer contract: valid and address/data stay stable until ready is observed. Changes made while WAITING are ignored because the values are latched.
- Reset mid-transaction aborts every transfer:
  - all FSMs go to IDLE;
  - all claimed bits clear;
  - rr_ptr = 0.
  - The memory side must tolerate a dropped request.

## Timing
- Reset values: all mem_*_valid, mem_*_address, mem_write_data, consumer_*_ready and consumer_read_data are 0.
- Request accepted at edge t (valid sampled, channel IDLE) → mem_*_valid high after edge t+1.
- mem_*_ready sampled high at edge u → consumer ready/data valid and mem valid low after edge u+1.
- Consumer valid sampled low at edge v → consumer ready low and channel IDLE after edge v+1. A new grant is possible at edge v+1 at the earliest.
- Minimum lane round trip with zero-wait memory: request seen → ready = 2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Single read: lane 0 reads addr 0x12; memory returns 0xAB one cycle after mem_read_valid → consumer_read_data[0]=0xAB; consumer_read_ready[0] rises 2 cycles after mem_read_valid and clears one cycle after lane 0 drops valid.
- Write: lane 5 writes 0x3C to 0x40 → mem_write_valid on channel 0 with addr 0x40 and data 0x3C; consumer_write_ready[5] rises after mem_write_ready.
- Contention: all 8 lanes read at once with 2 channels → grant order (0,1),(2,3),(4,5),(6,7); every lane completes; no lane is served twice; rr_ptr wraps to 0.
- Fairness: lane 0 re-requests immediately after each completion while lane 7 holds its request → lane 7 is granted within NUM_CONSUMERS/NUM_CHANNELS grant rounds.
- Reset mid-transfer: assert reset while channel 1 is in READ_WAITING → next cycle all valid/ready outputs are 0; a fresh request after reset completes normally.
- Read+write on the same lane: read completes first; the write is granted only after read valid drops.
